// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step/load controller: schedules cpu_ce, loads program RAM, PC breakpoint
module cpu_run_debounce #(
  parameter int DB_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic ev
);
  logic            s1, s2, level, level_q;
  logic [DB_W-1:0] cnt;

  // The level flips only after 2**DB_W consecutive synchronized samples disagree with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      level_q <= level;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == '1) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

  assign ev = level & ~level_q;
endmodule

module cpu_run_ctrl #(
  parameter int PC_W = 8,
  parameter int DIV  = 8,
  parameter int DB_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            btn_run,
  input  logic            btn_step,
  input  logic            ld_start,
  input  logic            ld_end,
  input  logic            ld_valid,
  input  logic [7:0]      ld_data,
  output logic            ld_ready,
  output logic            prog_we,
  output logic [PC_W-1:0] prog_waddr,
  output logic [7:0]      prog_wdata,
  input  logic [PC_W-1:0] pc,
  input  logic            bp_en,
  input  logic [PC_W-1:0] bp_addr,
  output logic            cpu_ce,
  output logic            cpu_rst_n,
  output logic [1:0]      state,
  output logic            bp_hit,
  output logic            ld_ovf
);
  localparam int PW = $clog2(DIV);

  // S_EXIT is the single post-load cycle that clears the CPU PC; reported as LOAD
  typedef enum logic [2:0] {S_HALT, S_RUN, S_STEP, S_LOAD, S_EXIT} st_t;
  st_t st, nxt;

  logic            run_ev, step_ev;
  logic [PW-1:0]   presc;
  logic            first_tick, tick, bp_stop, accept;
  logic [PC_W-1:0] addr, wbase;

  cpu_run_debounce #(.DB_W(DB_W)) u_db_run  (.clk(clk), .rst(reset), .raw(btn_run),  .ev(run_ev));
  cpu_run_debounce #(.DB_W(DB_W)) u_db_step (.clk(clk), .rst(reset), .raw(btn_step), .ev(step_ev));

  assign tick    = (presc == PW'(DIV - 1));
  assign bp_stop = tick & bp_en & (pc == bp_addr) & ~first_tick;
  assign accept  = ld_valid & ld_ready;
  assign wbase   = ld_start ? '0 : addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= S_HALT;
    else       st <= nxt;
  end

  always_comb begin
    nxt = st;
    case (st)
      S_HALT: begin
        if (ld_start)     nxt = S_LOAD;
        else if (run_ev)  nxt = S_RUN;
        else if (step_ev) nxt = S_STEP;
      end
      S_RUN: begin
        if (ld_start)     nxt = S_LOAD;
        else if (run_ev)  nxt = S_HALT;
        else if (bp_stop) nxt = S_HALT;
      end
      S_STEP:  nxt = ld_start ? S_LOAD : S_HALT;
      S_LOAD: begin
        if (ld_start)     nxt = S_LOAD;
        else if (ld_end)  nxt = S_EXIT;
      end
      S_EXIT:  nxt = ld_start ? S_LOAD : S_HALT;
      default: nxt = S_HALT;
    endcase
  end

  // Any ld_start suppresses the ce of the cycle it arrives in
  always_comb begin
    cpu_ce    = 1'b0;
    cpu_rst_n = 1'b1;
    ld_ready  = 1'b0;
    case (st)
      S_RUN:  cpu_ce = tick & ~bp_stop & ~run_ev & ~ld_start;
      S_STEP: cpu_ce = ~ld_start;
      S_LOAD: begin
        cpu_rst_n = 1'b0;
        ld_ready  = 1'b1;
      end
      S_EXIT: begin
        cpu_rst_n = 1'b0;
        cpu_ce    = ~ld_start;
      end
      default: ;
    endcase
  end

  assign state = (st == S_EXIT) ? 2'b11 : st[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc      <= '0;
      first_tick <= 1'b1;
      bp_hit     <= 1'b0;
      ld_ovf     <= 1'b0;
      addr       <= '0;
      prog_we    <= 1'b0;
      prog_waddr <= '0;
      prog_wdata <= '0;
    end else begin
      presc      <= (st == S_RUN && nxt == S_RUN) ? (tick ? '0 : presc + PW'(1)) : '0;
      first_tick <= (st != S_RUN) ? 1'b1 : (tick ? 1'b0 : first_tick);
      if (st == S_RUN && !ld_start && !run_ev && bp_stop) bp_hit <= 1'b1;
      else if (st == S_HALT && nxt == S_RUN)              bp_hit <= 1'b0;
      prog_we <= accept;
      if (accept) begin
        prog_waddr <= wbase;
        prog_wdata <= ld_data;
        addr       <= wbase + PC_W'(1);
      end else if (ld_start) begin
        addr <= '0;
      end
      if (accept && wbase == '1) ld_ovf <= 1'b1;
      else if (ld_start)         ld_ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - scoreboard bench for cpu_run_ctrl against a cycle-level reference model
module tb_cpu_run_ctrl;
  localparam int DIV = 4;
  localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_LOAD = 3, M_EXIT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_run = 1'b0, btn_step = 1'b0;
  logic       ld_start = 1'b0, ld_end = 1'b0, ld_valid = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic       ld_ready, prog_we;
  logic [7:0] prog_waddr, prog_wdata;
  logic [7:0] pc = 8'h00, pc_nx = 8'h00;
  logic       bp_en = 1'b0;
  logic [7:0] bp_addr = 8'h00;
  logic       cpu_ce, cpu_rst_n, bp_hit, ld_ovf;
  logic [1:0] state;

  cpu_run_ctrl #(.PC_W(8), .DIV(DIV), .DB_W(2)) dut (
    .clk(clk), .reset(reset), .btn_run(btn_run), .btn_step(btn_step),
    .ld_start(ld_start), .ld_end(ld_end), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .prog_we(prog_we), .prog_waddr(prog_waddr), .prog_wdata(prog_wdata),
    .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr), .cpu_ce(cpu_ce), .cpu_rst_n(cpu_rst_n),
    .state(state), .bp_hit(bp_hit), .ld_ovf(ld_ovf)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; bit rn; } ce_t;
  typedef struct { int cyc; logic [7:0] a; logic [7:0] d; } wr_t;
  typedef struct { int cyc; logic [1:0] st; bit bp; bit ovf; bit rn; bit rdy; logic [7:0] a; logic [7:0] d; } sts_t;

  ce_t  ceq[$];
  wr_t  wq[$];
  sts_t sq[$];

  int n_cmp = 0, n_bad = 0;
  logic [7:0] mem [256];

  // Reference model state, evaluated once per cycle at the falling edge
  int         m_cyc = 0, m_mode = M_HALT, m_rc = 0;
  bit         m_bp = 0, m_ovf = 0;
  logic [7:0] m_wa = 0, m_la = 0, m_ld = 0;
  bit [7:0]   h [2];
  bit         filt [2];
  bit         filt_p [2];

  always @(negedge clk) begin
    bit rev, sev, ce, acc, tick, bps, raw;
    logic [7:0] a;
    if (reset) begin
      m_mode = M_HALT; m_rc = 0; m_bp = 0; m_ovf = 0; m_wa = 0; m_la = 0; m_ld = 0;
      for (int b = 0; b < 2; b++) begin h[b] = 0; filt[b] = 0; filt_p[b] = 0; end
      ceq.delete();
      wq.delete();
      sq.push_back('{m_cyc, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00});
    end else begin
      rev = filt[0] & ~filt_p[0];
      sev = filt[1] & ~filt_p[1];
      for (int b = 0; b < 2; b++) begin
        raw = (b == 0) ? btn_run : btn_step;
        filt_p[b] = filt[b];
        if (h[b][4:1] == 4'hF) filt[b] = 1'b1;
        else if (h[b][4:1] == 4'h0) filt[b] = 1'b0;
        h[b] = {h[b][6:0], raw};
      end
      sq.push_back('{m_cyc, (m_mode == M_EXIT) ? 2'd3 : 2'(m_mode), m_bp, m_ovf,
                     !(m_mode == M_LOAD || m_mode == M_EXIT), m_mode == M_LOAD, m_la, m_ld});
      tick = (m_mode == M_RUN) && ((m_rc % DIV) == DIV - 1);
      bps  = tick && bp_en && (pc == bp_addr) && (m_rc != DIV - 1);
      case (m_mode)
        M_RUN:  ce = tick && !bps && !rev && !ld_start;
        M_STEP: ce = !ld_start;
        M_EXIT: ce = !ld_start;
        default: ce = 0;
      endcase
      if (ce) ceq.push_back('{m_cyc, m_mode != M_EXIT});
      acc = (m_mode == M_LOAD) && ld_valid;
      if (acc) begin
        a = ld_start ? 8'h00 : m_wa;
        wq.push_back('{m_cyc + 1, a, ld_data});
        m_la = a; m_ld = ld_data;
        if (a == 8'hFF) m_ovf = 1; else if (ld_start) m_ovf = 0;
        m_wa = a + 8'd1;
      end else if (ld_start) begin
        m_wa = 0; m_ovf = 0;
      end
      if (ld_start) m_mode = M_LOAD;
      else case (m_mode)
        M_HALT: if (rev) begin m_mode = M_RUN; m_rc = 0; m_bp = 0; end
                else if (sev) m_mode = M_STEP;
        M_RUN:  if (rev) m_mode = M_HALT;
                else if (bps) begin m_mode = M_HALT; m_bp = 1; end
                else m_rc++;
        M_STEP: m_mode = M_HALT;
        M_LOAD: if (ld_end) m_mode = M_EXIT;
        default: m_mode = M_HALT;
      endcase
    end
    m_cyc++;
  end

  int mon_cyc = 0;
  always @(negedge clk) begin
    sts_t s; ce_t c; wr_t w;
    #2;
    n_cmp++;
    if (sq.size() == 0) begin
      n_bad++; $display("FAIL status cyc %0d: no expectation queued", mon_cyc);
    end else begin
      s = sq.pop_front();
      if (s.cyc != mon_cyc || state !== s.st || bp_hit !== s.bp || ld_ovf !== s.ovf || cpu_rst_n !== s.rn ||
          ld_ready !== s.rdy || prog_waddr !== s.a || prog_wdata !== s.d) begin
        n_bad++;
        $display("FAIL status cyc %0d: got st=%0d bp=%b ovf=%b rn=%b rdy=%b wa=%h wd=%h, want cyc %0d st=%0d bp=%b ovf=%b rn=%b rdy=%b wa=%h wd=%h",
                 mon_cyc, state, bp_hit, ld_ovf, cpu_rst_n, ld_ready, prog_waddr, prog_wdata,
                 s.cyc, s.st, s.bp, s.ovf, s.rn, s.rdy, s.a, s.d);
      end
    end
    n_cmp++;
    if (ceq.size() != 0 && ceq[0].cyc == mon_cyc) begin
      c = ceq.pop_front();
      if (cpu_ce !== 1'b1 || cpu_rst_n !== c.rn) begin
        n_bad++; $display("FAIL cpu_ce cyc %0d: got ce=%b rn=%b, want ce=1 rn=%b", mon_cyc, cpu_ce, cpu_rst_n, c.rn);
      end
    end else if (cpu_ce !== 1'b0) begin
      n_bad++; $display("FAIL cpu_ce cyc %0d: got ce=%b, want 0", mon_cyc, cpu_ce);
    end
    n_cmp++;
    if (wq.size() != 0 && wq[0].cyc == mon_cyc) begin
      w = wq.pop_front();
      if (prog_we !== 1'b1 || prog_waddr !== w.a || prog_wdata !== w.d) begin
        n_bad++; $display("FAIL write cyc %0d: got we=%b a=%h d=%h, want we=1 a=%h d=%h", mon_cyc, prog_we, prog_waddr, prog_wdata, w.a, w.d);
      end
    end else if (prog_we !== 1'b0) begin
      n_bad++; $display("FAIL write cyc %0d: got we=%b, want 0", mon_cyc, prog_we);
    end
    if (prog_we === 1'b1) mem[prog_waddr] = prog_wdata;
    mon_cyc++;
  end

  // Toy CPU: pc advances on each ce and is cleared when ce arrives with reset low
  always @(negedge clk) begin
    #3;
    if (reset) pc_nx = 8'h00;
    else if (cpu_ce === 1'b1) pc_nx = (cpu_rst_n === 1'b1) ? pc + 8'd1 : 8'h00;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      pc = pc_nx;
    end
  endtask

  task automatic press(input int b, input int hold);
    if (b == 0) btn_run = 1'b1; else btn_step = 1'b1;
    cyc(hold);
    btn_run = 1'b0; btn_step = 1'b0;
    cyc(8);
  endtask

  task automatic send(input logic [7:0] d, input bit last);
    ld_valid = 1'b1; ld_data = d; ld_end = last;
    cyc(1);
    ld_valid = 1'b0; ld_end = 1'b0;
    cyc($urandom_range(0, 2));
  endtask

  task automatic pulse_start();
    ld_start = 1'b1; cyc(1); ld_start = 1'b0;
  endtask

  task automatic pulse_end();
    ld_end = 1'b1; cyc(1); ld_end = 1'b0; cyc(3);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  logic [7:0] bytes [257];

  initial begin
    cyc(3);
    reset = 1'b0;
    cyc(4);
    // run / halt toggling
    press(0, 8);
    cyc(30);
    press(0, 8);
    cyc(12);
    // step and a too-short glitch
    press(1, 8);
    cyc(6);
    press(1, 3);
    cyc(6);
    // small load
    pulse_start();
    send(8'h81, 0); cyc(2);
    send(8'h42, 0); cyc(1);
    send(8'h10, 0);
    pulse_end();
    chk("mem0_small", mem[0], 8'h81);
    chk("mem1_small", mem[1], 8'h42);
    chk("mem2_small", mem[2], 8'h10);
    // wrapping load, last byte arrives together with ld_end
    for (int i = 0; i < 257; i++) bytes[i] = 8'($urandom);
    pulse_start();
    for (int i = 0; i < 257; i++) send(bytes[i], i == 256);
    cyc(3);
    @(negedge clk); #2;
    chk("ld_ovf_set", ld_ovf, 1);
    chk("mem0_wrapped", mem[0], bytes[256]);
    chk("mem1_wrapped", mem[1], bytes[1]);
    chk("mem255_wrapped", mem[255], bytes[255]);
    cyc(1);
    pulse_start();
    cyc(1);
    @(negedge clk); #2;
    chk("ld_ovf_cleared", ld_ovf, 0);
    cyc(1);
    pulse_end();
    // breakpoint at pc 5
    bp_en = 1'b1; bp_addr = 8'h05;
    press(0, 8);
    cyc(40);
    @(negedge clk); #2;
    chk("bp_hit_set", bp_hit, 1);
    chk("bp_halt_state", state, 2'b00);
    chk("bp_pc", pc, 8'h05);
    cyc(1);
    press(0, 8);
    cyc(10);
    @(negedge clk); #2;
    chk("bp_hit_cleared", bp_hit, 0);
    cyc(1);
    press(0, 8);
    bp_en = 1'b0;
    // ld_start colliding with run_ev while running, then reset mid-load
    press(0, 8);
    cyc(5);
    btn_run = 1'b1;
    cyc(6);
    ld_start = 1'b1;
    cyc(1);
    ld_start = 1'b0;
    cyc(2);
    btn_run = 1'b0;
    send(8'h5A, 0);
    send(8'hA5, 0);
    ld_valid = 1'b1; ld_data = 8'h33;
    cyc(1);
    ld_valid = 1'b0;
    #2 reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(8);
    // randomized mix
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: press(0, $urandom_range(2, 8));
        1: press(1, $urandom_range(2, 8));
        2: begin
          int n;
          n = $urandom_range(1, 6);
          pulse_start();
          for (int k = 0; k < n; k++) send(8'($urandom), (k == n - 1) && ($urandom_range(0, 1) == 1));
          pulse_end();
        end
        3: begin bp_en = 1'($urandom); bp_addr = pc + 8'($urandom_range(0, 6)); cyc(2); end
        default: cyc($urandom_range(1, 20));
      endcase
    end
    cyc(10);
    @(negedge clk); #3;
    chk("ce_queue_drained", ceq.size(), 0);
    chk("write_queue_drained", wq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
